steer_en_ctrl: RTL and testbench

//  Rider-detect / steering-enable sequencer feeding balance_cntrl's rider_off and en_steer inputs.

---
 rtl/steer_en_ctrl_pkg.sv | 19 +
 rtl/steer_en_ctrl_if.sv | 26 ++
 rtl/steer_en_ctrl_tmr.sv | 29 ++
 rtl/steer_en_ctrl.sv | 124 ++++++++++++
 tb/tb_steer_en_ctrl.sv | 136 +++++++++++++
 5 files changed

// File: rtl/steer_en_ctrl_pkg.sv
// Shared types and default thresholds for the rider-detect / steering-enable sequencer.
// The bench imports this package as well.
package steer_en_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } steer_state_t;

    localparam logic [11:0] DEF_MIN_RIDER_WT = 12'h200;
    localparam logic [11:0] DEF_WT_HYST      = 12'h040;
    localparam int unsigned DEF_TMR_W        = 26;

    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/steer_en_ctrl_if.sv
// Load-cell sample strobe and steering/rider status between A2D side and balance_cntrl.
interface steer_en_ctrl_if;

    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    modport master (
        output ld_vld,
        output lft_ld,
        output rght_ld,
        input  en_steer,
        input  rider_off
    );

    modport slave (
        input  ld_vld,
        input  lft_ld,
        input  rght_ld,
        output en_steer,
        output rider_off
    );

endinterface

// File: rtl/steer_en_ctrl_tmr.sv
// Saturating settle timer; clear has priority over increment.
module steer_en_ctrl_tmr #(
    parameter int unsigned TMR_W = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic full
);

    logic [TMR_W-1:0] cnt_r;

    // Settle counter: holds at all-ones until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && !(&cnt_r)) begin
            cnt_r <= cnt_r + TMR_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign full = &cnt_r;

endmodule

// File: rtl/steer_en_ctrl.sv
// Rider-detect / steering-enable sequencer: qualifies rider weight and balance from the
// registered load-cell samples and enables steering after a level settle period.
module steer_en_ctrl
    import steer_en_ctrl_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT = DEF_MIN_RIDER_WT,
    parameter logic [11:0] WT_HYST      = DEF_WT_HYST,
    parameter int unsigned TMR_W        = DEF_TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    steer_en_ctrl_if.slave   bus
);

    localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    logic [11:0]  lft_q_r;
    logic [11:0]  rght_q_r;
    logic [12:0]  sum_s;
    logic [11:0]  diff_s;
    logic         sum_gt_min_s;
    logic         sum_lt_min_s;
    logic         diff_gt_1_4_s;
    logic         diff_gt_15_16_s;
    logic         tmr_inc_s;
    logic         tmr_clr_s;
    logic         tmr_full_s;
    steer_state_t state_r;
    steer_state_t state_nxt_s;
    logic         en_steer_r;
    logic         rider_off_r;

    // Sample registers: every decision works from these, never from the raw bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            lft_q_r  <= 12'h000;
            rght_q_r <= 12'h000;
        end else if (bus.ld_vld) begin
            lft_q_r  <= bus.lft_ld;
            rght_q_r <= bus.rght_ld;
        end else begin
            lft_q_r  <= lft_q_r;
            rght_q_r <= rght_q_r;
        end
    end

    assign sum_s  = {1'b0, lft_q_r} + {1'b0, rght_q_r};
    assign diff_s = abs_diff(lft_q_r, rght_q_r);

    assign sum_gt_min_s    = (sum_s > SUM_HI);
    assign sum_lt_min_s    = (sum_s < SUM_LO);
    assign diff_gt_1_4_s   = ({1'b0, diff_s} > (sum_s >> 2));
    assign diff_gt_15_16_s = ({1'b0, diff_s} > (sum_s - (sum_s >> 4)));

    // Next-state and timer control; timer is held clear outside WAIT so entry starts at 0.
    always_comb begin
        state_nxt_s = IDLE;
        tmr_inc_s   = 1'b0;
        tmr_clr_s   = 1'b1;
        case (state_r)
            IDLE: begin
                if (sum_gt_min_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                tmr_clr_s = 1'b0;
                if (sum_lt_min_s) begin
                    state_nxt_s = IDLE;
                end else if (diff_gt_1_4_s) begin
                    state_nxt_s = WAIT;
                    tmr_clr_s   = 1'b1;
                end else if (tmr_full_s) begin
                    state_nxt_s = STEER_EN;
                end else begin
                    state_nxt_s = WAIT;
                    tmr_inc_s   = 1'b1;
                end
            end
            STEER_EN: begin
                if (sum_lt_min_s) begin
                    state_nxt_s = IDLE;
                end else if (diff_gt_15_16_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = STEER_EN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register with Moore outputs decoded from the next state so they stay in step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            en_steer_r  <= 1'b0;
            rider_off_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            en_steer_r  <= (state_nxt_s == STEER_EN);
            rider_off_r <= (state_nxt_s == IDLE);
        end
    end

    steer_en_ctrl_tmr #(
        .TMR_W (TMR_W)
    ) u_tmr (
        .clk  (clk),
        .rst  (rst),
        .inc  (tmr_inc_s),
        .clr  (tmr_clr_s),
        .full (tmr_full_s)
    );

    assign bus.en_steer  = en_steer_r;
    assign bus.rider_off = rider_off_r;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl with a 15-bit settle timer (32768-cycle settle).
module tb_steer_en_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    steer_en_ctrl_if bus ();

    steer_en_ctrl #(
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h040),
        .TMR_W        (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en_exp, input logic off_exp);
        check({tag, ".en_steer"}, bus.en_steer, en_exp);
        check({tag, ".rider_off"}, bus.rider_off, off_exp);
    endtask

    // Returns 1 time unit after the edge that captured the sample.
    task automatic load(input logic [11:0] l, input logic [11:0] r);
        @(posedge clk);
        #1;
        bus.ld_vld  = 1'b1;
        bus.lft_ld  = l;
        bus.rght_ld = r;
        @(posedge clk);
        #1;
        bus.ld_vld  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        rst         = 1'b1;
        bus.ld_vld  = 1'b0;
        bus.lft_ld  = 12'h000;
        bus.rght_ld = 12'h000;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 1'b1);
        rst = 1'b0;
        step(3);
        check_out("idle_no_load", 1'b0, 1'b1);

        // IDLE boundaries: sum exactly at threshold and in the hysteresis band stay IDLE
        load(12'h100, 12'h100);
        step(2);
        check_out("idle_sum_eq_min", 1'b0, 1'b1);
        load(12'h0E8, 12'h0E8);
        step(2);
        check_out("idle_band", 1'b0, 1'b1);

        // 2: mount level, two-cycle latency then full settle
        load(12'h180, 12'h180);
        check_out("mount_latency", 1'b0, 1'b1);
        step(1);
        check_out("mount_wait", 1'b0, 1'b0);
        step(32767);
        check_out("settle_not_before", 1'b0, 1'b0);
        step(1);
        check_out("settle_done", 1'b1, 1'b0);

        // 4: mild lean keeps steering; band and lower threshold keep steering
        load(12'h300, 12'h100);
        step(2);
        check_out("steer_mild_lean", 1'b1, 1'b0);
        load(12'h0E8, 12'h0E8);
        step(2);
        check_out("steer_band", 1'b1, 1'b0);
        load(12'h0E0, 12'h0E0);
        step(2);
        check_out("steer_sum_eq_lo", 1'b1, 1'b0);
        load(12'h400, 12'h010);
        check_out("lean_latency", 1'b1, 1'b0);
        step(1);
        check_out("lean_to_wait", 1'b0, 1'b0);

        // 5: dismount below hysteresis threshold
        load(12'h0D8, 12'h0D8);
        step(1);
        check_out("dismount", 1'b0, 1'b1);

        // 3: unlevel during settle restarts the timer
        load(12'h180, 12'h180);
        step(1);
        check_out("remount", 1'b0, 1'b0);
        step(20000);
        load(12'h300, 12'h080);
        step(2);
        check_out("unlevel_wait", 1'b0, 1'b0);
        load(12'h180, 12'h180);
        step(32767);
        check_out("resettle_not_before", 1'b0, 1'b0);
        step(1);
        check_out("resettle_done", 1'b1, 1'b0);

        // 6: reset while steering; cleared samples keep it in IDLE afterwards
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        check_out("rst_in_steer", 1'b0, 1'b1);
        rst = 1'b0;
        step(3);
        check_out("post_rst_idle", 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
